// File: rtl/clock_divider_prog.sv
// Programmable clock divider: toggle (50% duty) or pulse output, with a
// shadowed divisor/mode load that takes effect at a terminal count.
module clock_divider_prog #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 9000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             mode_in,
    output logic             sclk,
    output logic             tick,
    output logic             load_ack
);

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
    mode_e            mode_q, mode_d;
    mode_e            shadow_mode_q, shadow_mode_d;
    logic             pend_q, pend_d;
    logic             sclk_q, sclk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;

    logic             terminal;
    logic             apply;
    logic             eff_pend;

    // A div_load in the current cycle is treated as already pending, so a
    // load coincident with a terminal (or with en=0) applies at this edge.
    always_comb begin
        shadow_div_d  = div_load ? div_in : shadow_div_q;
        shadow_mode_d = div_load ? mode_e'(mode_in) : shadow_mode_q;
        eff_pend      = pend_q | div_load;
        terminal      = en && !clr && (count_q == div_q);
        apply         = eff_pend && !clr && (terminal || !en);

        count_d = count_q;
        div_d   = div_q;
        mode_d  = mode_q;
        pend_d  = eff_pend;
        sclk_d  = sclk_q;
        tick_d  = 1'b0;
        ack_d   = 1'b0;

        if (clr) begin
            count_d = '0;
            sclk_d  = 1'b0;
        end else begin
            if (terminal) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else if (en) begin
                count_d = count_q + WIDTH'(1);
            end

            if (apply) begin
                div_d  = shadow_div_d;
                mode_d = shadow_mode_d;
                pend_d = 1'b0;
                ack_d  = 1'b1;
                if (!terminal && (count_q > shadow_div_d)) begin
                    count_d = '0;
                end
            end

            if (mode_d == MODE_PULSE) begin
                sclk_d = tick_d;
            end else if (apply && (mode_q == MODE_PULSE)) begin
                sclk_d = 1'b0;
            end else if (terminal) begin
                sclk_d = ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q       <= '0;
            div_q         <= WIDTH'(DEFAULT_DIV);
            mode_q        <= MODE_TOGGLE;
            shadow_div_q  <= '0;
            shadow_mode_q <= MODE_TOGGLE;
            pend_q        <= 1'b0;
            sclk_q        <= 1'b0;
            tick_q        <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            count_q       <= count_d;
            div_q         <= div_d;
            mode_q        <= mode_d;
            shadow_div_q  <= shadow_div_d;
            shadow_mode_q <= shadow_mode_d;
            pend_q        <= pend_d;
            sclk_q        <= sclk_d;
            tick_q        <= tick_d;
            ack_q         <= ack_d;
        end
    end

    assign sclk     = sclk_q;
    assign tick     = tick_q;
    assign load_ack = ack_q;

endmodule

// File: doc/clock_divider_prog.md
CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the counter and divisor width in bits.
REQ-002 The module SHALL have parameter DEFAULT_DIV, default 9000000, giving the terminal count loaded at reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit: count enable.
REQ-006 The module SHALL have port clr, input, 1 bit: synchronous clear of counter and outputs.
REQ-007 The module SHALL have port div_in, input, WIDTH bits: new terminal count.
REQ-008 The module SHALL have port div_load, input, 1 bit: single-cycle request to capture div_in.
REQ-009 The module SHALL have port mode_in, input, 1 bit: 0 selects toggle (50% duty), 1 selects pulse.
REQ-010 The module SHALL have port sclk, output, 1 bit: divided clock, registered.
REQ-011 The module SHALL have port tick, output, 1 bit: one-cycle pulse at each terminal count, registered.
REQ-012 The module SHALL have port load_ack, output, 1 bit: one-cycle pulse when a pending divisor takes effect.

Function
REQ-013 Internal state SHALL be count, div_reg (active divisor), mode_reg, shadow_div, and pending flag.
REQ-014 When en=1 and count != div_reg, count SHALL increment by 1 per cycle.
REQ-015 When en=1 and count == div_reg (terminal), count SHALL go to 0 and tick SHALL be 1 in the next cycle.
REQ-016 In toggle mode, sclk SHALL invert at each terminal, giving period 2*(div_reg+1) clk cycles.
REQ-017 In pulse mode, sclk SHALL equal tick, high one cycle every div_reg+1 cycles.
REQ-018 div_reg=0 SHALL be legal: terminal every cycle; toggle-mode sclk = clk/2, pulse-mode sclk constantly 1 while en=1.
REQ-019 count SHALL never exceed div_reg; arithmetic is unsigned WIDTH bits; no wrap past div_reg.
REQ-020 div_load=1 SHALL capture div_in and mode_in into shadow registers and set pending; a later div_load before apply SHALL overwrite the shadow (last wins).
REQ-021 Pending values SHALL be applied to div_reg/mode_reg at the next terminal if en=1, or on the next cycle if en=0; pending SHALL clear and load_ack SHALL pulse 1 for that cycle.
REQ-022 div_load coincident with a terminal SHALL apply the new div_in at that terminal, with load_ack in the same cycle as tick.
REQ-023 On a mode change to pulse, sclk SHALL go to 0 at the applying terminal except for the tick cycle; on a change to toggle, sclk SHALL start from 0.
REQ-024 When en=0, count and sclk SHALL hold, tick SHALL be 0; on en returning to 1, counting SHALL resume from the held count.
REQ-025 clr=1 SHALL set count=0, sclk=0, tick=0 next cycle, leave div_reg, mode_reg and any pending load intact, and take priority over en and terminal.
REQ-026 clr and div_load in the same cycle SHALL both take effect; the load applies at the next terminal per REQ-021.

Reset
REQ-027 reset=0 SHALL immediately force count=0, sclk=0, tick=0, load_ack=0, pending=0, div_reg=DEFAULT_DIV, mode_reg=0, regardless of clk.
REQ-028 Assertion of reset mid-period SHALL discard any pending load; after release, counting SHALL start from 0 on the first enabled edge.

Verification
REQ-029 DEFAULT_DIV=3, en=1, mode 0 -> sclk toggles every 4 cycles (period 8), tick every 4 cycles.
REQ-030 div_load with div_in=1 at count=1 of div 3 -> no change until terminal, then load_ack with tick, thereafter tick every 2 cycles.
REQ-031 mode_in=1, div_in=0 loaded with en=0 -> load_ack next cycle; en=1 -> sclk and tick high every cycle.
REQ-032 en dropped at count=2 for 5 cycles -> count, sclk frozen, tick 0; resumes, terminal 2 enabled cycles later.
REQ-033 clr at count=2 with pending load -> count 0, sclk 0 next cycle; load applied at the following terminal.
REQ-034 reset pulsed low mid-period between clk edges -> outputs 0 immediately, div_reg back to 3, pending lost.
